pim_bus_slave: RTL and testbench

// - Bus responder at the PIM end of the DMA PIM port.
// - Decodes word accesses to CTRL/R/W_WEIGHT/W_ACTIVATION/W_KEY/W_VREF windows and drives the PIM macro.
// - Returns the status word polled by the DMA (bit0 busy, bit1 data_valid).
// - Buffers macro results for sequential readout through the R window.

---
 rtl/pim_pkg.sv | 16 +
 rtl/pim_res_buf.sv | 39 +++
 rtl/pim_bus_slave.sv | 126 ++++++++++++
 tb/tb_pim_bus_slave.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pim_pkg.sv
// pim_pkg: address map, status bit positions and FSM state type for the PIM bus responder.
package pim_pkg;
  localparam logic [31:0] PIM_CTRL         = 32'h4000_0010;
  localparam logic [31:0] PIM_R            = 32'h4000_0020;
  localparam logic [31:0] PIM_W_WEIGHT     = 32'h4000_0040;
  localparam logic [31:0] PIM_W_ACTIVATION = 32'h4000_0080;
  localparam logic [31:0] PIM_W_KEY        = 32'h4000_0100;
  localparam logic [31:0] PIM_W_VREF       = 32'h4000_0200;
  localparam int ACT_WORDS = 8;
  localparam int RES_WORDS = 8;
  localparam int WADDR_W   = 8;
  localparam int ST_BUSY  = 0;
  localparam int ST_VALID = 1;
  localparam int ST_ERR   = 2;
  typedef enum logic [2:0] {IDLE, LOAD_ACT, COMPUTE, COLLECT, VALID} e_pim_state;
endpackage

// File: rtl/pim_res_buf.sv
// pim_res_buf: result buffer filled once by the macro and drained in order by bus reads.
module pim_res_buf
  import pim_pkg::*;
#(
  parameter int DEPTH = RES_WORDS
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        clr,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  output logic        full,
  output logic        empty,
  output logic        last
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(DEPTH + 1);
  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  assign full    = wr_ptr == PW'(DEPTH);
  assign empty   = rd_ptr == wr_ptr;
  assign last    = rd_ptr == PW'(DEPTH - 1);
  assign rd_data = empty ? 32'h0 : mem[rd_ptr[AW-1:0]];
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  always_ff @(posedge i_clk)
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
endmodule

// File: rtl/pim_bus_slave.sv
// pim_bus_slave: decodes DMA word accesses into PIM macro weight/activation/key/vref traffic and buffers results.
module pim_bus_slave
  import pim_pkg::*;
#(
  parameter int P_ACT_WORDS = ACT_WORDS,
  parameter int P_RES_WORDS = RES_WORDS
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [31:0]        i_addr,
  input  logic               i_write,
  input  logic               i_read,
  input  logic [3:0]         i_size,
  input  logic [31:0]        i_wr_data,
  output logic [31:0]        o_rd_data,
  output logic [3:0]         o_macro_sel,
  output logic               o_w_we,
  output logic [WADDR_W-1:0] o_w_addr,
  output logic [31:0]        o_w_data,
  output logic               o_act_valid,
  output logic [31:0]        o_act_data,
  output logic               o_compute_start,
  input  logic               i_macro_done,
  input  logic               i_res_valid,
  input  logic [31:0]        i_res_data,
  output logic [31:0]        o_key,
  output logic [31:0]        o_vref
);
  localparam int CW = P_ACT_WORDS > 1 ? $clog2(P_ACT_WORDS) : 1;
  e_pim_state        state, nxt;
  logic              err;
  logic [WADDR_W-1:0] w_ptr;
  logic [CW-1:0]     act_cnt;
  logic [31:0]       win, status, buf_rd;
  logic [3:0]        sel;
  logic hit_ctrl, hit_r, hit_w, hit_act, hit_key, hit_vref, hit_macro;
  logic req, legal, wr_ok, rd_ok, busy, act_state, act_ok, act_last;
  logic soft_rst, r_ok, err_set, buf_clr, buf_full, buf_empty, buf_last;
  assign win       = i_addr & ~32'hF;
  assign sel       = i_addr[3:0];
  assign hit_ctrl  = win == PIM_CTRL;
  assign hit_r     = win == PIM_R;
  assign hit_w     = win == PIM_W_WEIGHT;
  assign hit_act   = win == PIM_W_ACTIVATION;
  assign hit_key   = win == PIM_W_KEY;
  assign hit_vref  = win == PIM_W_VREF;
  assign hit_macro = hit_w || hit_act || hit_key || hit_vref;
  // CTRL ignores the sel nibble; every other window needs exactly one sel bit
  assign req       = i_write || i_read;
  assign legal     = i_size == 4'b1111 && (hit_ctrl || ($onehot(sel) && (hit_r || hit_macro)));
  assign wr_ok     = i_write && legal;
  assign rd_ok     = i_read && legal && !i_write;
  assign busy      = state == COMPUTE || state == COLLECT;
  assign act_state = state == IDLE || state == LOAD_ACT;
  assign act_ok    = wr_ok && hit_act && act_state;
  assign act_last  = act_ok && act_cnt == CW'(P_ACT_WORDS - 1);
  assign soft_rst  = wr_ok && hit_ctrl && i_wr_data[0];
  assign r_ok      = rd_ok && hit_r && state == VALID;
  assign buf_clr   = soft_rst || (r_ok && buf_last);
  assign status    = {29'b0, err, state == VALID, busy};
  assign err_set   = (req && !legal) || (i_write && i_read) || (wr_ok && hit_w && busy) ||
                     (wr_ok && hit_act && !act_state) || (i_read && legal && hit_r && state != VALID);
  pim_res_buf #(.DEPTH(P_RES_WORDS)) u_buf (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .clr     (buf_clr),
    .wr_en   (i_res_valid && state == COLLECT),
    .wr_data (i_res_data),
    .rd_en   (r_ok),
    .rd_data (buf_rd),
    .full    (buf_full),
    .empty   (buf_empty),
    .last    (buf_last)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = act_last ? COMPUTE : act_ok ? LOAD_ACT : IDLE;
      LOAD_ACT: nxt = act_last ? COMPUTE : LOAD_ACT;
      COMPUTE:  nxt = i_macro_done ? COLLECT : COMPUTE;
      COLLECT:  nxt = buf_full ? VALID : COLLECT;
      VALID:    nxt = r_ok && buf_last ? IDLE : VALID;
      default:  nxt = IDLE;
    endcase
    if (soft_rst) nxt = IDLE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      err             <= 1'b0;
      act_cnt         <= '0;
      w_ptr           <= '0;
      o_rd_data       <= '0;
      o_macro_sel     <= '0;
      o_w_we          <= 1'b0;
      o_w_addr        <= '0;
      o_w_data        <= '0;
      o_act_valid     <= 1'b0;
      o_act_data      <= '0;
      o_compute_start <= 1'b0;
      o_key           <= '0;
      o_vref          <= '0;
    end else begin
      err             <= (err && !soft_rst) || err_set;
      act_cnt         <= soft_rst || act_last ? '0 : act_ok ? act_cnt + 1'b1 : act_cnt;
      o_rd_data       <= !rd_ok ? 32'h0 : hit_ctrl ? status : r_ok ? buf_rd : 32'h0;
      o_w_we          <= wr_ok && hit_w && !busy;
      o_act_valid     <= act_ok;
      o_compute_start <= act_last;
      if (req && legal && hit_macro) o_macro_sel <= sel;
      if (wr_ok && hit_w && !busy) begin
        o_w_addr <= w_ptr;
        o_w_data <= i_wr_data;
        w_ptr    <= w_ptr + 1'b1;
      end
      if (wr_ok && hit_ctrl && i_wr_data[1]) begin
        o_w_addr <= '0;
        w_ptr    <= '0;
      end
      if (act_ok) o_act_data <= i_wr_data;
      if (wr_ok && hit_key) o_key <= i_wr_data;
      if (wr_ok && hit_vref) o_vref <= i_wr_data;
    end
endmodule

// File: tb/tb_pim_bus_slave.sv
// tb_pim_bus_slave: table-driven and sequenced checks with a read-data scoreboard.
module tb_pim_bus_slave;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0, wr_data = '0, res_data = '0;
  logic        write = 1'b0, read = 1'b0, macro_done = 1'b0, res_valid = 1'b0;
  logic [3:0]  size = 4'hF;
  logic [31:0] rd_data, w_data, act_data, key, vref;
  logic [3:0]  macro_sel;
  logic        w_we, act_valid, compute_start;
  logic [7:0]  w_addr;
  int          errors = 0, checks = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic        rd;
    logic [3:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;
  vec_t tbl[8];

  localparam logic [31:0] CTRL = 32'h4000_0010;

  pim_bus_slave dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_addr          (addr),
    .i_write         (write),
    .i_read          (read),
    .i_size          (size),
    .i_wr_data       (wr_data),
    .o_rd_data       (rd_data),
    .o_macro_sel     (macro_sel),
    .o_w_we          (w_we),
    .o_w_addr        (w_addr),
    .o_w_data        (w_data),
    .o_act_valid     (act_valid),
    .o_act_data      (act_data),
    .o_compute_start (compute_start),
    .i_macro_done    (macro_done),
    .i_res_valid     (res_valid),
    .i_res_data      (res_data),
    .o_key           (key),
    .o_vref          (vref)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input logic [31:0] a, input logic wr, input logic rd, input logic [3:0] sz,
                     input logic [31:0] wd, input logic [31:0] exp_rd);
    addr = a; write = wr; read = rd; size = sz; wr_data = wd;
    if (rd) exp_q.push_back(exp_rd);
    cyc();
    write = 1'b0; read = 1'b0; size = 4'hF;
  endtask

  task automatic ctrl_rd(input logic [31:0] exp);
    acc(CTRL, 1'b0, 1'b1, 4'hF, 32'h0, exp);
  endtask

  always @(posedge clk)
    if (rst_n && read) begin
      #2;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_data: got %h expected none queued", rd_data);
      end else chk("rd_data", rd_data, exp_q.pop_front());
    end

  initial begin
    tbl[0] = '{32'h4000_0104, 1, 0, 4'hF, 32'hCAFE_0001, 32'h0, 0};
    tbl[1] = '{32'h4000_0208, 1, 0, 4'hF, 32'h0000_00A5, 32'h0, 0};
    tbl[2] = '{32'h4000_0022, 0, 1, 4'hF, 32'h0, 32'h0, 1};
    tbl[3] = '{32'h4000_0300, 0, 1, 4'hF, 32'h0, 32'h0, 1};
    tbl[4] = '{32'h4000_0023, 0, 1, 4'hF, 32'h0, 32'h0, 1};
    tbl[5] = '{32'h4000_0101, 1, 0, 4'b0011, 32'hFFFF_FFFF, 32'h0, 1};
    tbl[6] = '{CTRL, 1, 1, 4'hF, 32'h0, 32'h0, 1};
    tbl[7] = '{32'h4000_0040, 1, 0, 4'hF, 32'h1234_5678, 32'h0, 1};

    repeat (2) cyc();
    chk("rst rd_data", rd_data, 0);
    chk("rst w_we", 32'(w_we), 0);
    chk("rst macro_sel", 32'(macro_sel), 0);
    chk("rst key", key, 0);
    rst_n = 1'b1;
    cyc();
    ctrl_rd(32'h0);

    for (int i = 0; i < 3; i++) begin
      acc(32'h4000_0041, 1, 0, 4'hF, 32'hA0 + 32'(i), 32'h0);
      chk("w_we", 32'(w_we), 1);
      chk("w_addr", 32'(w_addr), i);
      chk("w_data", w_data, 32'hA0 + 32'(i));
      chk("macro_sel w", 32'(macro_sel), 32'h1);
    end
    cyc();
    chk("w_we idle", 32'(w_we), 0);

    for (int i = 0; i < 8; i++) begin
      acc(tbl[i].addr, tbl[i].wr, tbl[i].rd, tbl[i].size, tbl[i].wdata, tbl[i].exp_rd);
      ctrl_rd({29'b0, tbl[i].exp_err, 2'b0});
      if (tbl[i].exp_err) begin
        acc(CTRL, 1, 0, 4'hF, 32'h1, 32'h0);
        ctrl_rd(32'h0);
      end
    end
    chk("key", key, 32'hCAFE_0001);
    chk("vref", vref, 32'h0000_00A5);
    chk("macro_sel vref", 32'(macro_sel), 32'h8);
    chk("w_addr kept", 32'(w_addr), 2);

    for (int i = 0; i < 8; i++) begin
      acc(32'h4000_0082, 1, 0, 4'hF, 32'h100 + 32'(i), 32'h0);
      chk("act_valid", 32'(act_valid), 1);
      chk("act_data", act_data, 32'h100 + 32'(i));
      chk("compute_start", 32'(compute_start), 32'(i == 7));
    end
    chk("macro_sel act", 32'(macro_sel), 32'h2);
    cyc();
    chk("act_valid idle", 32'(act_valid), 0);
    chk("start idle", 32'(compute_start), 0);
    ctrl_rd(32'h1);
    res_valid = 1'b1; res_data = 32'hDEAD;
    cyc();
    res_valid = 1'b0;
    macro_done = 1'b1;
    cyc();
    macro_done = 1'b0;
    ctrl_rd(32'h1);
    for (int i = 0; i < 8; i++) begin
      res_valid = 1'b1; res_data = 32'h10 + 32'(i);
      cyc();
    end
    res_valid = 1'b0;
    cyc();
    ctrl_rd(32'h2);
    res_valid = 1'b1; res_data = 32'hBAD;
    cyc();
    res_valid = 1'b0;
    for (int i = 0; i < 8; i++) acc(32'h4000_0022, 0, 1, 4'hF, 32'h0, 32'h10 + 32'(i));
    ctrl_rd(32'h0);

    for (int i = 0; i < 8; i++) acc(32'h4000_0082, 1, 0, 4'hF, 32'h200 + 32'(i), 32'h0);
    acc(32'h4000_0041, 1, 0, 4'hF, 32'h55, 32'h0);
    chk("w_we busy", 32'(w_we), 0);
    chk("w_addr busy", 32'(w_addr), 2);
    ctrl_rd(32'h5);
    macro_done = 1'b1;
    cyc();
    macro_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      res_valid = 1'b1; res_data = 32'h30 + 32'(i);
      cyc();
    end
    res_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst rd_data", rd_data, 0);
    chk("arst key", key, 0);
    chk("arst vref", vref, 0);
    chk("arst macro_sel", 32'(macro_sel), 0);
    chk("arst w_addr", 32'(w_addr), 0);
    chk("arst act_valid", 32'(act_valid), 0);
    chk("arst start", 32'(compute_start), 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    ctrl_rd(32'h0);
    repeat (3) cyc();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
